uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 147 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a 4-entry byte FIFO.
// A byte pushed into an empty FIFO is popped on the next edge, and the start bit begins immediately after that edge.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       UART_TX,
  output logic       tx_busy,
  output logic [2:0] tx_count
);

  localparam int              CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      DEPTH     = 3'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       wr_ptr_q, wr_ptr_d;
  logic [1:0]       rd_ptr_q, rd_ptr_d;
  logic [2:0]       count_q, count_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic [7:0]       mem_q [4];

  logic push;
  logic pop;
  logic baud_done;

  // A full FIFO refuses a push even if a pop frees a slot on the same edge.
  assign tx_ready  = (count_q != DEPTH);
  assign push      = tx_valid && tx_ready && !reset;
  assign pop       = (state_q == IDLE) && (count_q != 3'd0);
  assign baud_done = (baud_q == BAUD_LAST);

  assign UART_TX  = tx_q;
  assign tx_busy  = (state_q != IDLE);
  assign tx_count = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 2'd1;
    if (pop)  rd_ptr_d = rd_ptr_q + 2'd1;
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          shift_d   = mem_q[rd_ptr_q];
          baud_d    = '0;
          bit_idx_d = 3'd0;
          state_d   = START;
        end
      end
      START: begin
        if (baud_done) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_d  = '0;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The line level is decoded from the next state so the output flop lines up with the state change.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[bit_idx_d];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      wr_ptr_q  <= 2'd0;
      rd_ptr_q  <= 2'd0;
      count_q   <= 3'd0;
      baud_q    <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at 4 clocks per bit; the line, busy and count are logged after every rising edge.
module tb_uart_tx_fifo;
  localparam int CPB  = 4;
  localparam int MAXC = 4096;

  logic       sys_clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       UART_TX;
  logic       tx_busy;
  logic [2:0] tx_count;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  logic line_log [0:MAXC-1];
  logic busy_log [0:MAXC-1];
  logic [2:0] count_log [0:MAXC-1];

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .UART_TX (UART_TX),
    .tx_busy (tx_busy),
    .tx_count(tx_count)
  );

  always #5 sys_clk = ~sys_clk;

  // Entry i holds the outputs just after rising edge number i.
  always @(posedge sys_clk) begin
    #1;
    if (cyc < MAXC) begin
      line_log[cyc]  = UART_TX;
      busy_log[cyc]  = tx_busy;
      count_log[cyc] = tx_count;
    end
    cyc = cyc + 1;
  end

  function automatic logic frame_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i == 9) return 1'b1;
    return b[i-1];
  endfunction

  task automatic wait_idle(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge sys_clk);
      if (!tx_busy && tx_count == 3'd0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    #1;
    reset    = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 8'h77;
    @(negedge sys_clk);
    n_checks++; if (UART_TX !== 1'b1) $display("FAIL reset_line: got %b want 1", UART_TX); else n_pass++;
    n_checks++; if (tx_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", tx_busy); else n_pass++;
    n_checks++; if (tx_count !== 3'd0) $display("FAIL reset_count: got %0d want 0", tx_count); else n_pass++;
    n_checks++; if (tx_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", tx_ready); else n_pass++;
    @(negedge sys_clk);
    n_checks++; if (tx_count !== 3'd0) $display("FAIL reset_push_ignored: got %0d want 0", tx_count); else n_pass++;
    reset    = 1'b0;
    tx_valid = 1'b0;
  endtask

  task automatic test_single;
    int c;
    int nbusy;
    @(negedge sys_clk);
    c        = cyc;
    tx_data  = 8'h41;
    tx_valid = 1'b1;
    @(negedge sys_clk);
    tx_valid = 1'b0;
    n_checks++; if (tx_count !== 3'd1) $display("FAIL single_count_after_push: got %0d want 1", tx_count); else n_pass++;
    n_checks++; if (UART_TX !== 1'b1) $display("FAIL single_line_push_edge: got %b want 1", UART_TX); else n_pass++;
    n_checks++; if (tx_busy !== 1'b0) $display("FAIL single_busy_push_edge: got %b want 0", tx_busy); else n_pass++;
    repeat (48) @(negedge sys_clk);
    n_checks++; if (count_log[c+1] !== 3'd0) $display("FAIL single_count_after_pop: got %0d want 0", count_log[c+1]); else n_pass++;
    for (int k = 0; k < 10 * CPB; k++) begin
      n_checks++;
      if (line_log[c+1+k] !== frame_bit(8'h41, k / CPB))
        $display("FAIL single_line[%0d]: got %b want %b", k, line_log[c+1+k], frame_bit(8'h41, k / CPB));
      else n_pass++;
    end
    nbusy = 0;
    for (int k = 0; k < 46; k++) if (busy_log[c+k] === 1'b1) nbusy++;
    n_checks++; if (nbusy !== 40) $display("FAIL single_busy_cycles: got %0d want 40", nbusy); else n_pass++;
    n_checks++; if (line_log[c+41] !== 1'b1) $display("FAIL single_line_after: got %b want 1", line_log[c+41]); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int c;
    int s;
    @(negedge sys_clk);
    c        = cyc;
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    @(negedge sys_clk);
    tx_data  = 8'hAA;
    @(negedge sys_clk);
    tx_valid = 1'b0;
    n_checks++; if (tx_count !== 3'd1) $display("FAIL b2b_count_push_pop: got %0d want 1", tx_count); else n_pass++;
    repeat (92) @(negedge sys_clk);
    s = c + 1;
    for (int k = 0; k < 86; k++) begin
      logic exp;
      if (k < 40)      exp = frame_bit(8'h55, k / CPB);
      else if (k < 41) exp = 1'b1;
      else if (k < 81) exp = frame_bit(8'hAA, (k - 41) / CPB);
      else             exp = 1'b1;
      n_checks++;
      if (line_log[s+k] !== exp) $display("FAIL b2b_line[%0d]: got %b want %b", k, line_log[s+k], exp);
      else n_pass++;
    end
  endtask

  task automatic test_overflow;
    int c;
    int s;
    int bad;
    bit ok;
    @(negedge sys_clk);
    c = cyc;
    for (int i = 0; i < 6; i++) begin
      tx_data  = 8'(i + 1);
      tx_valid = 1'b1;
      if (i == 5) begin
        n_checks++; if (tx_count !== 3'd4) $display("FAIL ovf_count_full: got %0d want 4", tx_count); else n_pass++;
        n_checks++; if (tx_ready !== 1'b0) $display("FAIL ovf_ready_full: got %b want 0", tx_ready); else n_pass++;
      end
      @(negedge sys_clk);
    end
    tx_valid = 1'b0;
    n_checks++; if (tx_count !== 3'd4) $display("FAIL ovf_count_after_drop: got %0d want 4", tx_count); else n_pass++;
    repeat (5 * 41 + 30) @(negedge sys_clk);
    s = c + 1;
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 10; j++) begin
        n_checks++;
        if (line_log[s + 41*i + CPB*j + 1] !== frame_bit(8'(i + 1), j))
          $display("FAIL ovf_frame%0d_bit%0d: got %b want %b", i + 1, j, line_log[s + 41*i + CPB*j + 1], frame_bit(8'(i + 1), j));
        else n_pass++;
      end
      n_checks++;
      if (line_log[s + 41*i + 40] !== 1'b1) $display("FAIL ovf_gap%0d: got %b want 1", i, line_log[s + 41*i + 40]);
      else n_pass++;
    end
    bad = 0;
    for (int k = 205; k < 225; k++) if (line_log[s+k] !== 1'b1) bad++;
    n_checks++; if (bad !== 0) $display("FAIL ovf_sixth_dropped: got %0d low cycles want 0", bad); else n_pass++;
    wait_idle(20, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL ovf_idle_timeout: got %b want 1", ok); else n_pass++;
  endtask

  task automatic test_reset_mid_frame;
    int c;
    int s;
    int bad;
    @(negedge sys_clk);
    c        = cyc;
    tx_data  = 8'h0F;
    tx_valid = 1'b1;
    @(negedge sys_clk);
    tx_data  = 8'h11;
    @(negedge sys_clk);
    tx_data  = 8'h22;
    @(negedge sys_clk);
    tx_valid = 1'b0;
    s = c + 1;
    while (cyc < s + 18) @(negedge sys_clk);
    n_checks++; if (tx_count !== 3'd2) $display("FAIL rst_mid_count_before: got %0d want 2", tx_count); else n_pass++;
    n_checks++; if (tx_busy !== 1'b1) $display("FAIL rst_mid_busy_before: got %b want 1", tx_busy); else n_pass++;
    n_checks++; if (line_log[s+4] !== 1'b1) $display("FAIL rst_mid_bit0: got %b want 1", line_log[s+4]); else n_pass++;
    reset    = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 8'h99;
    #1;
    n_checks++; if (UART_TX !== 1'b1) $display("FAIL rst_mid_line: got %b want 1", UART_TX); else n_pass++;
    n_checks++; if (tx_busy !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", tx_busy); else n_pass++;
    n_checks++; if (tx_count !== 3'd0) $display("FAIL rst_mid_count: got %0d want 0", tx_count); else n_pass++;
    n_checks++; if (tx_ready !== 1'b1) $display("FAIL rst_mid_ready: got %b want 1", tx_ready); else n_pass++;
    repeat (2) @(negedge sys_clk);
    n_checks++; if (tx_count !== 3'd0) $display("FAIL rst_mid_push_ignored: got %0d want 0", tx_count); else n_pass++;
    reset    = 1'b0;
    tx_valid = 1'b0;
    c = cyc;
    repeat (52) @(negedge sys_clk);
    bad = 0;
    for (int k = 0; k < 50; k++) if (line_log[c+k] !== 1'b1 || busy_log[c+k] !== 1'b0) bad++;
    n_checks++; if (bad !== 0) $display("FAIL rst_mid_no_resume: got %0d active cycles want 0", bad); else n_pass++;
    n_checks++; if (tx_count !== 3'd0) $display("FAIL rst_mid_count_after: got %0d want 0", tx_count); else n_pass++;
  endtask

  task automatic test_wrap;
    int c;
    int s;
    bit ok;
    logic [7:0] bytes [4];
    bytes[0] = 8'hA1;
    bytes[1] = 8'hB2;
    bytes[2] = 8'hC3;
    bytes[3] = 8'hD4;
    // Two bytes through a freshly reset FIFO leave both pointers at 2.
    @(negedge sys_clk);
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    @(negedge sys_clk);
    tx_data  = 8'h5A;
    @(negedge sys_clk);
    tx_valid = 1'b0;
    wait_idle(200, ok);
    n_checks++; if (ok !== 1'b1) $display("FAIL wrap_prep_timeout: got %b want 1", ok); else n_pass++;
    @(negedge sys_clk);
    c = cyc;
    for (int i = 0; i < 3; i++) begin
      tx_data  = bytes[i];
      tx_valid = 1'b1;
      @(negedge sys_clk);
    end
    tx_valid = 1'b0;
    n_checks++; if (tx_count !== 3'd2) $display("FAIL wrap_count_queued: got %0d want 2", tx_count); else n_pass++;
    while (cyc < c + 42) @(negedge sys_clk);
    n_checks++; if (tx_busy !== 1'b0) $display("FAIL wrap_idle_gap: got %b want 0", tx_busy); else n_pass++;
    n_checks++; if (tx_count !== 3'd2) $display("FAIL wrap_count_before: got %0d want 2", tx_count); else n_pass++;
    tx_data  = bytes[3];
    tx_valid = 1'b1;
    @(negedge sys_clk);
    tx_valid = 1'b0;
    n_checks++; if (tx_count !== 3'd2) $display("FAIL wrap_count_push_pop: got %0d want 2", tx_count); else n_pass++;
    n_checks++; if (tx_busy !== 1'b1) $display("FAIL wrap_busy_after_pop: got %b want 1", tx_busy); else n_pass++;
    repeat (4 * 41 + 10) @(negedge sys_clk);
    s = c + 1;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 10; j++) begin
        n_checks++;
        if (line_log[s + 41*i + CPB*j + 2] !== frame_bit(bytes[i], j))
          $display("FAIL wrap_frame%0d_bit%0d: got %b want %b", i, j, line_log[s + 41*i + CPB*j + 2], frame_bit(bytes[i], j));
        else n_pass++;
      end
    end
    n_checks++; if (tx_count !== 3'd0) $display("FAIL wrap_count_end: got %0d want 0", tx_count); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_reset_mid_frame();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
